// File: rtl/slider_key_cmd.sv
// ---------------------------------------------------------------------------
// slider_key_cmd
//
// Turns four raw push-buttons into one-cycle step strobes for the slider
// position block. Each key is polarity-normalised, passed through a 2-flop
// synchroniser, debounced, and then fed to a repeat FSM. The FSM emits one
// step on press, a second step REPEAT_DELAY cycles later, and then one step
// every repeat period while the key stays held.
//
// Optional feature (compile-time macro SLIDER_KEY_ACCEL_EN):
//   After ACCEL_COUNT repeat pulses, the repeat period drops to
//   max(1, REPEAT_PERIOD/2). When the macro is undefined, the period is
//   always REPEAT_PERIOD and no pulse counter is built.
//
// Ports:
//   iVGA_CLK      clock (all logic in this domain)
//   iRST          synchronous, active-high reset
//   iKEY_go       raw key, +x
//   iKEY_back     raw key, -x
//   iKEY_up       raw key, -y
//   iKEY_down     raw key, +y
//   oSlider_go    one-cycle step strobe, +x
//   oSlider_back  one-cycle step strobe, -x
//   oSlider_up    one-cycle step strobe, -y
//   oSlider_down  one-cycle step strobe, +y
//   oKeys_held    registered debounced levels {down, up, back, go}
// ---------------------------------------------------------------------------
module slider_key_cmd #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 250000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned ACCEL_COUNT     = 8,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iKEY_go,
    input  logic       iKEY_back,
    input  logic       iKEY_up,
    input  logic       iKEY_down,
    output logic       oSlider_go,
    output logic       oSlider_back,
    output logic       oSlider_up,
    output logic       oSlider_down,
    output logic [3:0] oKeys_held
);

    localparam logic [CNT_W-1:0] DebTerm    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayTerm  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodTerm = CNT_W'(REPEAT_PERIOD - 1);
    localparam longint unsigned  CntMax     = (64'd1 << CNT_W) - 64'd1;

`ifdef SLIDER_KEY_ACCEL_EN
    localparam int unsigned      FastPeriod = (REPEAT_PERIOD / 2 == 0) ? 1 : REPEAT_PERIOD / 2;
    localparam logic [CNT_W-1:0] FastTerm   = CNT_W'(FastPeriod - 1);
    localparam logic [CNT_W-1:0] AccelTerm  = CNT_W'(ACCEL_COUNT);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_e;

    // Key vectors are ordered {down, up, back, go}, matching oKeys_held.
    logic [3:0] key_raw;
    logic [3:0] key_norm;
    logic [3:0] deb_lvl;
    logic [3:0] step;
    logic [3:0] pass_mask;
    logic [3:0] strobe_q;
    logic [3:0] held_q;
    logic       x_conflict;
    logic       y_conflict;

    assign key_raw  = {iKEY_down, iKEY_up, iKEY_back, iKEY_go};
    assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < 4; i++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             deb_q;
        logic             step_q;
        logic [CNT_W-1:0] db_cnt_q;
        logic [CNT_W-1:0] rc_q;
        logic [CNT_W-1:0] period_term;
        rep_state_e       state_q;

`ifdef SLIDER_KEY_ACCEL_EN
        logic [CNT_W-1:0] acc_q;
        assign period_term = (acc_q == AccelTerm) ? FastTerm : PeriodTerm;
`else
        assign period_term = PeriodTerm;
`endif

        // Synchroniser and debounce. Reset loads the released level (0).
        always_ff @(posedge iVGA_CLK) begin
            if (iRST) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                deb_q    <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                sync1_q <= key_norm[i];
                sync2_q <= sync1_q;
                if (sync2_q == deb_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DebTerm) begin
                    deb_q    <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end
        end

        // Repeat FSM. IDLE is only left while the debounced level is high and
        // is re-entered as soon as it drops, so "IDLE with level high" is the
        // rising edge of the debounced level.
        always_ff @(posedge iVGA_CLK) begin
            if (iRST || !deb_q) begin
                state_q <= StIdle;
                rc_q    <= '0;
                step_q  <= 1'b0;
`ifdef SLIDER_KEY_ACCEL_EN
                acc_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    StIdle: begin
                        step_q  <= 1'b1;
                        rc_q    <= '0;
                        state_q <= StDelay;
                    end
                    StDelay: begin
                        if (rc_q == DelayTerm) begin
                            step_q  <= 1'b1;
                            rc_q    <= '0;
                            state_q <= StRepeat;
                        end else begin
                            step_q <= 1'b0;
                            rc_q   <= rc_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rc_q == period_term) begin
                            step_q <= 1'b1;
                            rc_q   <= '0;
`ifdef SLIDER_KEY_ACCEL_EN
                            if (acc_q != AccelTerm) begin
                                acc_q <= acc_q + 1'b1;
                            end
`endif
                        end else begin
                            step_q <= 1'b0;
                            rc_q   <= rc_q + 1'b1;
                        end
                    end
                    default: begin
                        step_q  <= 1'b0;
                        rc_q    <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end

        assign deb_lvl[i] = deb_q;
        assign step[i]    = step_q;
    end

    // Opposing keys held together cancel each other's strobes; their FSMs
    // keep running so the survivor resumes on its existing cadence.
    assign x_conflict = deb_lvl[0] & deb_lvl[1];
    assign y_conflict = deb_lvl[2] & deb_lvl[3];
    assign pass_mask  = {~y_conflict, ~y_conflict, ~x_conflict, ~x_conflict};

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            strobe_q <= 4'b0000;
            held_q   <= 4'b0000;
        end else begin
            strobe_q <= step & pass_mask;
            held_q   <= deb_lvl;
        end
    end

    assign oSlider_go   = strobe_q[0];
    assign oSlider_back = strobe_q[1];
    assign oSlider_up   = strobe_q[2];
    assign oSlider_down = strobe_q[3];
    assign oKeys_held   = held_q;

    // Every timing parameter must be at least 1 and fit in a CNT_W counter.
    param_fit_a: assert property (@(posedge iVGA_CLK)
        (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1) &&
        (64'(DEBOUNCE_CYCLES) <= CntMax) && (64'(REPEAT_DELAY) <= CntMax) &&
        (64'(REPEAT_PERIOD) <= CntMax) && (64'(ACCEL_COUNT) <= CntMax));

endmodule
